pb_event_conditioner: RTL
=========================

// Module: pb_event_conditioner
// PURPOSE
//  Conditions one raw push-button into clean single-cycle events for the event counters
//  and the 7-seg display path.
//  2-flop synchroniser, then a debounce FSM. Emits press, release and long-press pulses,
//  plus an optional auto-repeat pulse stream.
//  Drop-in upstream stage: PB_pressed_pulse feeds nbit_counter.PB_in directly.
// PARAMETERS
//  DELAY          5      consecutive stable cycles needed to accept a press or a release (>=1)
//  LONG_PRESS     1000   debounced-held cycles, counted from the press pulse, to flag a long press (>=1)
//  REPEAT_PERIOD  250    cycles between auto-repeat pulses while long-held (>=1)
// PORTS
//  clock              in   1  system clock; all logic on its rising edge
//  reset              in   1  synchronous, active-high reset
//  PB                 in   1  raw asynchronous button level, 1 = pressed
//  PB_pressed_pulse   out  1  1-cycle pulse on accepted press
//  PB_released_pulse  out  1  1-cycle pulse on accepted release
//  PB_long_pulse      out  1  1-cycle pulse when hold reaches LONG_PRESS
//  PB_repeat_pulse    out  1  auto-repeat pulses (see CONFIGURATION)
//  PB_status          out  1  debounced level, 1 = button considered down
// BEHAVIOUR
//  - Reset: FSM=IDLE; sync flops, all counters and all outputs = 0. Reset wins over every
//    other event, including reset mid-debounce or mid-hold; no pulse is issued on reset.
//  - Sync: s1<=PB, pb_sync<=s1. FSM sees only pb_sync.
//  - Edge numbering: edge 1 = first edge sampling PB=1.
//    With PB held high, pb_sync=1 after edge 2; stable count reaches DELAY at edge DELAY+2.
//  - All outputs registered; each pulse is high exactly one cycle.
//  - Counters: stable counter sized $clog2(DELAY+1).
//    Hold counter sized $clog2(LONG_PRESS+1) and saturates at LONG_PRESS.
//  - States:
//    IDLE: pb_sync=1 -> PRESS_WAIT, stable_cnt<=1.
//          If DELAY==1, go straight to PRESSED and issue the press pulse.
//    PRESS_WAIT: pb_sync=0 -> IDLE, no pulse (glitch rejected).
//          Else stable_cnt++; on reaching DELAY -> PRESSED, PB_pressed_pulse=1, hold_cnt<=0.
//    PRESSED: pb_sync=1 -> hold_cnt++; on reaching LONG_PRESS -> LONG_HELD, PB_long_pulse=1.
//          pb_sync=0 -> RELEASE_WAIT, stable_cnt<=1, was_long<=0.
//    LONG_HELD: pb_sync=0 -> RELEASE_WAIT, stable_cnt<=1, was_long<=1.
//    RELEASE_WAIT: pb_sync=1 -> back to PRESSED or LONG_HELD (per was_long), no pulse,
//          hold_cnt frozen (release bounce ignored). Else stable_cnt++; on reaching DELAY
//          -> IDLE, PB_released_pulse=1.
//  - PB_status=1 in PRESSED, LONG_HELD and RELEASE_WAIT; 0 in IDLE and PRESS_WAIT.
//    It rises with the press pulse and falls with the release pulse.
//  - PB_long_pulse fires at most once per press.
//    Press and long pulses never coincide, even for LONG_PRESS=1 (long comes one cycle later).
// CONFIGURATION
//  PB_AUTOREPEAT_EN defined:
//  - In LONG_HELD, rep_cnt counts while pb_sync=1.
//  - PB_repeat_pulse fires REPEAT_PERIOD cycles after PB_long_pulse, then every
//    REPEAT_PERIOD cycles.
//  - rep_cnt clears on entry to LONG_HELD and freezes in RELEASE_WAIT.
//  PB_AUTOREPEAT_EN undefined: PB_repeat_pulse tied 0; no repeat counter synthesised.
// TESTING
//  - Use DELAY=4, LONG_PRESS=20, REPEAT_PERIOD=8.
//  - Clean press: PB 0->1, held -> press pulse in the cycle after edge 6; PB_status=1 from then.
//  - Glitch: PB high 3 cycles then low -> no pulses, PB_status stays 0.
//  - Release bounce: after press, PB toggles low 2 / high 1 / low 10 -> exactly one release
//    pulse, DELAY cycles after the final low is synchronised; no extra press pulse.
//  - Long hold + macro: hold 60 cycles after press -> long pulse at hold_cnt=20, repeat
//    pulses 8, 16, 24... cycles later; without macro, repeat stays 0.
//  - Reset mid-hold: reset asserted in LONG_HELD -> next cycle all outputs 0, FSM IDLE.
//    With PB still high, a fresh press pulse comes DELAY+2 edges after reset deasserts.
//  - Count check: 5 clean press/release pairs -> 5 press and 5 release pulses;
//    a downstream nbit_counter reads 5.

Source files
------------

// File: rtl/pb_event_conditioner.sv
// Push-button conditioner: 2-flop synchroniser plus debounce FSM producing press/release/long pulses.
// Define PB_AUTOREPEAT_EN to build the auto-repeat pulse stream while the button is long-held.
module pb_event_conditioner #(
  parameter int DELAY         = 5,
  parameter int LONG_PRESS    = 1000,
  parameter int REPEAT_PERIOD = 250
) (
  input  logic clock,
  input  logic reset,
  input  logic PB,
  output logic PB_pressed_pulse,
  output logic PB_released_pulse,
  output logic PB_long_pulse,
  output logic PB_repeat_pulse,
  output logic PB_status
);

  localparam int SW = $clog2(DELAY + 1);
  localparam int HW = $clog2(LONG_PRESS + 1);
  localparam logic [SW-1:0] DELAY_V = SW'(DELAY);
  localparam logic [HW-1:0] LONG_V  = HW'(LONG_PRESS);

  typedef enum logic [2:0] {
    IDLE, PRESS_WAIT, PRESSED, LONG_HELD, RELEASE_WAIT
  } state_t;

  state_t        r_state, w_state_next;
  logic          r_s1, r_sync;
  logic [SW-1:0] r_stable, w_stable_next, w_stable_inc;
  logic [HW-1:0] r_hold, w_hold_next, w_hold_inc;
  logic          r_was_long, w_was_long_next;
  logic          r_press, w_press_next;
  logic          r_release, w_release_next;
  logic          r_long, w_long_next;
  logic          r_status, w_status_next;

  assign w_stable_inc = r_stable + SW'(1);
  assign w_hold_inc   = r_hold + HW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1       <= 1'b0;
      r_sync     <= 1'b0;
      r_state    <= IDLE;
      r_stable   <= '0;
      r_hold     <= '0;
      r_was_long <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_long     <= 1'b0;
      r_status   <= 1'b0;
    end else begin
      r_s1       <= PB;
      r_sync     <= r_s1;
      r_state    <= w_state_next;
      r_stable   <= w_stable_next;
      r_hold     <= w_hold_next;
      r_was_long <= w_was_long_next;
      r_press    <= w_press_next;
      r_release  <= w_release_next;
      r_long     <= w_long_next;
      r_status   <= w_status_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_stable_next   = r_stable;
    w_hold_next     = r_hold;
    w_was_long_next = r_was_long;
    w_press_next    = 1'b0;
    w_release_next  = 1'b0;
    w_long_next     = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_sync) begin
          if (DELAY == 1) begin
            w_state_next = PRESSED;
            w_press_next = 1'b1;
            w_hold_next  = '0;
          end else begin
            w_state_next  = PRESS_WAIT;
            w_stable_next = SW'(1);
          end
        end
      end
      PRESS_WAIT: begin
        if (!r_sync) begin
          w_state_next = IDLE;
        end else begin
          w_stable_next = w_stable_inc;
          if (w_stable_inc == DELAY_V) begin
            w_state_next = PRESSED;
            w_press_next = 1'b1;
            w_hold_next  = '0;
          end
        end
      end
      PRESSED, LONG_HELD: begin
        if (!r_sync) begin
          w_was_long_next = (r_state == LONG_HELD);
          // A one-cycle debounce accepts the release on the first low sample.
          if (DELAY == 1) begin
            w_state_next   = IDLE;
            w_release_next = 1'b1;
          end else begin
            w_state_next  = RELEASE_WAIT;
            w_stable_next = SW'(1);
          end
        end else if (r_state == PRESSED) begin
          w_hold_next = w_hold_inc;
          if (w_hold_inc == LONG_V) begin
            w_state_next = LONG_HELD;
            w_long_next  = 1'b1;
          end
        end
      end
      RELEASE_WAIT: begin
        if (r_sync) begin
          w_state_next = r_was_long ? LONG_HELD : PRESSED;
        end else begin
          w_stable_next = w_stable_inc;
          if (w_stable_inc == DELAY_V) begin
            w_state_next   = IDLE;
            w_release_next = 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
    w_status_next = (w_state_next == PRESSED) || (w_state_next == LONG_HELD) ||
                    (w_state_next == RELEASE_WAIT);
  end

  assign PB_pressed_pulse  = r_press;
  assign PB_released_pulse = r_release;
  assign PB_long_pulse     = r_long;
  assign PB_status         = r_status;

`ifdef PB_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_PERIOD + 1);
  localparam logic [RW-1:0] REP_V = RW'(REPEAT_PERIOD);

  logic [RW-1:0] r_rep, w_rep_inc;
  logic          r_repeat;

  assign w_rep_inc = r_rep + RW'(1);

  // Phase is restarted by the long pulse and simply held across release bounce.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rep    <= '0;
      r_repeat <= 1'b0;
    end else begin
      r_repeat <= 1'b0;
      if (w_long_next) begin
        r_rep <= '0;
      end else if (r_state == LONG_HELD && r_sync) begin
        if (w_rep_inc == REP_V) begin
          r_rep    <= '0;
          r_repeat <= 1'b1;
        end else begin
          r_rep <= w_rep_inc;
        end
      end
    end
  end

  assign PB_repeat_pulse = r_repeat;
`else
  // Low for every legal period; no repeat counter exists in this build.
  assign PB_repeat_pulse = (REPEAT_PERIOD < 1);
`endif

endmodule
